// File: rtl/ex_mem_pkg.sv
// EX/MEM shared types: payload bundle and buffer state encodings.
// Imported by the interface, the skid buffer and the stage top.
package ex_mem_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] alu_result;
    logic             is_write_dmem;
    logic [1:0]       wb_select;
    logic [7:0]       write_width;
    logic [WIDTH-1:0] dmem_write_data;
    logic [4:0]       rd;
    logic             reg_write;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM valid/ready handshake with the memory-stage payload fields.
// master drives valid and payload, slave returns ready.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] alu_result;
  logic             is_write_dmem;
  logic [1:0]       wb_select;
  logic [7:0]       write_width;
  logic [WIDTH-1:0] dmem_write_data;
  logic [4:0]       rd;
  logic             reg_write;

  modport master (
    output valid,
    output alu_result,
    output is_write_dmem,
    output wb_select,
    output write_width,
    output dmem_write_data,
    output rd,
    output reg_write,
    input  ready
  );

  modport slave (
    input  valid,
    input  alu_result,
    input  is_write_dmem,
    input  wb_select,
    input  write_width,
    input  dmem_write_data,
    input  rd,
    input  reg_write,
    output ready
  );

endinterface

// File: rtl/ex_mem_skid.sv
// Generic two-entry skid buffer: main drives the output, skid absorbs
// the one extra entry so in_ready depends only on registered state.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // payload registers keep their contents, they are just invalid
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= ST_TWO;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_q <= skid_q;
            skid_q <= '0;
            state  <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: packs EX fields into the skid buffer,
// unpacks the head entry onto the MEM side and counts stall cycles.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        flush,
  ex_mem_if.slave     ex,
  ex_mem_if.master    mem,
  output logic [15:0] stall_cnt
);

  ex_mem_payload_t in_pl;
  ex_mem_payload_t out_pl;
  logic            out_valid;
  logic            in_ready;

  assign in_pl = {
    ex.alu_result,
    ex.is_write_dmem,
    ex.wb_select,
    ex.write_width,
    ex.dmem_write_data,
    ex.rd,
    ex.reg_write
  };

  ex_mem_skid #(
    .W($bits(ex_mem_payload_t))
  ) u_skid (
    .clk      (sys_clk),
    .rst_n    (sys_rst),
    .flush    (flush),
    .in_valid (ex.valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(mem.ready),
    .out_data (out_pl)
  );

  assign ex.ready            = in_ready;
  assign mem.valid           = out_valid;
  assign mem.alu_result      = out_pl.alu_result;
  assign mem.wb_select       = out_pl.wb_select;
  assign mem.write_width     = out_pl.write_width;
  assign mem.dmem_write_data = out_pl.dmem_write_data;
  assign mem.rd              = out_pl.rd;
  // side-effecting controls must never leak from a stale entry
  assign mem.is_write_dmem   = out_pl.is_write_dmem & out_valid;
  assign mem.reg_write       = out_pl.reg_write & out_valid;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stall_cnt <= '0;
    end else if (ex.valid && !in_ready &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: handshake, ordering, flush, reset,
// and stall counter saturation against hand-computed values.
module tb_ex_mem;
  import ex_mem_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        flush   = 1'b0;
  logic [15:0] stall_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  ex_mem_if ex_if ();
  ex_mem_if mem_if ();

  ex_mem dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .flush    (flush),
    .ex       (ex_if),
    .mem      (mem_if),
    .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(logic [31:0] a);
    ex_if.valid           = 1'b1;
    ex_if.alu_result      = a;
    ex_if.dmem_write_data = ~a;
    ex_if.rd              = a[4:0];
    ex_if.reg_write       = 1'b1;
    ex_if.is_write_dmem   = 1'b1;
    ex_if.wb_select       = 2'b01;
    ex_if.write_width     = 8'h0F;
  endtask

  task automatic idle();
    ex_if.valid = 1'b0;
  endtask

  task automatic nx();
    @(negedge sys_clk);
  endtask

  initial begin
    ex_if.valid           = 1'b0;
    ex_if.alu_result      = '0;
    ex_if.dmem_write_data = '0;
    ex_if.rd              = '0;
    ex_if.reg_write       = 1'b0;
    ex_if.is_write_dmem   = 1'b0;
    ex_if.wb_select       = '0;
    ex_if.write_width     = '0;
    mem_if.ready          = 1'b0;

    #2;
    chk("rst_valid", 32'(mem_if.valid), 0);
    chk("rst_ready", 32'(ex_if.ready), 1);
    chk("rst_alu", mem_if.alu_result, 0);
    chk("rst_wr", 32'(mem_if.reg_write), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    nx();
    sys_rst = 1'b1;

    // single transfer, one cycle latency
    send(32'h10);
    mem_if.ready = 1'b1;
    nx();
    chk("lat_valid", 32'(mem_if.valid), 1);
    chk("lat_alu", mem_if.alu_result, 32'h10);
    chk("lat_rd", 32'(mem_if.rd), 32'h10);
    chk("lat_data", mem_if.dmem_write_data, ~32'h10);
    chk("lat_ready", 32'(ex_if.ready), 1);
    idle();
    nx();
    chk("drain_valid", 32'(mem_if.valid), 0);
    chk("drain_regw", 32'(mem_if.reg_write), 0);
    chk("drain_dmw", 32'(mem_if.is_write_dmem), 0);

    // backpressure: A,B accepted, C held
    mem_if.ready = 1'b0;
    send(32'hA1);
    nx();
    chk("bp_a_rdy", 32'(ex_if.ready), 1);
    chk("bp_a_alu", mem_if.alu_result, 32'hA1);
    send(32'hB2);
    nx();
    chk("bp_b_rdy", 32'(ex_if.ready), 0);
    chk("bp_b_alu", mem_if.alu_result, 32'hA1);
    chk("bp_b_stall", 32'(stall_cnt), 0);
    send(32'hC3);
    for (int i = 1; i <= 3; i++) begin
      nx();
      chk("bp_stall", 32'(stall_cnt), 32'(i));
      chk("bp_hold", mem_if.alu_result, 32'hA1);
    end
    mem_if.ready = 1'b1;
    nx();
    chk("out_b", mem_if.alu_result, 32'hB2);
    chk("out_b_rdy", 32'(ex_if.ready), 1);
    chk("out_b_stall", 32'(stall_cnt), 4);
    nx();
    chk("out_c", mem_if.alu_result, 32'hC3);
    chk("out_c_v", 32'(mem_if.valid), 1);
    idle();
    nx();
    chk("out_end_v", 32'(mem_if.valid), 0);

    // flush in TWO with a simultaneous EX request
    mem_if.ready = 1'b0;
    send(32'hD4);
    nx();
    send(32'hE5);
    nx();
    chk("fl_two_rdy", 32'(ex_if.ready), 0);
    send(32'hF6);
    flush = 1'b1;
    nx();
    flush = 1'b0;
    idle();
    chk("fl_valid", 32'(mem_if.valid), 0);
    chk("fl_rdy", 32'(ex_if.ready), 1);
    chk("fl_regw", 32'(mem_if.reg_write), 0);
    chk("fl_stall", 32'(stall_cnt), 5);
    mem_if.ready = 1'b1;
    nx();
    chk("fl_none", 32'(mem_if.valid), 0);

    // flush in ONE discards the accepted transfer
    mem_if.ready = 1'b0;
    send(32'h77);
    nx();
    send(32'h88);
    flush = 1'b1;
    nx();
    flush = 1'b0;
    idle();
    chk("fl1_valid", 32'(mem_if.valid), 0);
    nx();
    chk("fl1_none", 32'(mem_if.valid), 0);

    // streaming: one output per cycle
    mem_if.ready = 1'b1;
    send(32'h100);
    for (int k = 1; k <= 10; k++) begin
      nx();
      chk("st_valid", 32'(mem_if.valid), 1);
      chk("st_alu", mem_if.alu_result, 32'h100 + 32'(k - 1));
      chk("st_rdy", 32'(ex_if.ready), 1);
      if (k < 10) send(32'h100 + 32'(k));
      else idle();
    end
    nx();
    chk("st_end", 32'(mem_if.valid), 0);

    // async reset pulse while in TWO
    mem_if.ready = 1'b0;
    send(32'h31);
    nx();
    send(32'h32);
    nx();
    send(32'h33);
    nx();
    chk("ar_pre_stall", 32'(stall_cnt), 6);
    #2;
    sys_rst = 1'b0;
    #1;
    chk("ar_valid", 32'(mem_if.valid), 0);
    chk("ar_alu", mem_if.alu_result, 0);
    chk("ar_rd", 32'(mem_if.rd), 0);
    chk("ar_rdy", 32'(ex_if.ready), 1);
    chk("ar_stall", 32'(stall_cnt), 0);
    sys_rst = 1'b1;
    idle();
    nx();
    send(32'h55);
    mem_if.ready = 1'b1;
    nx();
    chk("ar_first", mem_if.alu_result, 32'h55);
    chk("ar_first_v", 32'(mem_if.valid), 1);
    idle();
    nx();

    // stall counter saturation
    mem_if.ready = 1'b0;
    send(32'h61);
    nx();
    send(32'h62);
    nx();
    send(32'h63);
    repeat (65534) nx();
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    nx();
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (3) nx();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat_alu", mem_if.alu_result, 32'h61);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
